// File: rtl/labs_pkg.sv
// Shared types and constants for the LABS search sequencer.
package labs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // All-ones energy of a given width; used as the "nothing seen yet" best value.
    function automatic logic [63:0] e_max(input int unsigned w);
        if (w >= 64) begin
            e_max = '1;
        end else begin
            e_max = (64'd1 << w) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/labs_best_tracker.sv
// Tracks the minimum energy, the first sequence reaching it, and the saturating tie count.
module labs_best_tracker
    import labs_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = 8,
    parameter int unsigned E_WIDTH   = 20,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [SEQ_WIDTH-1:0] res_seq,
    input  logic [E_WIDTH-1:0]   res_e,
    output logic [SEQ_WIDTH-1:0] best_seq,
    output logic [E_WIDTH-1:0]   best_e,
    output logic [CNT_WIDTH-1:0] ties
);

    localparam logic [E_WIDTH-1:0] E_MAX = E_WIDTH'(e_max(E_WIDTH));

    // Strictly lower energy restarts the tie count; equal energy keeps the first sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_seq <= '0;
            best_e   <= E_MAX;
            ties     <= '0;
        end else if (clear) begin
            best_seq <= '0;
            best_e   <= E_MAX;
            ties     <= '0;
        end else if (valid) begin
            if (res_e < best_e) begin
                best_e   <= res_e;
                best_seq <= res_seq;
                ties     <= CNT_WIDTH'(1);
            end else if (res_e == best_e) begin
                if (ties != '1) begin
                    ties <= ties + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/labs_search_ctrl.sv
// Enumerates a sequence range into calc_e, one per cycle, and collects the minimum energy.
module labs_search_ctrl
    import labs_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = 8,
    parameter int unsigned E_WIDTH   = 20,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEQ_WIDTH-1:0] cfg_first,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic [SEQ_WIDTH-1:0] best_seq,
    output logic [E_WIDTH-1:0]   best_e,
    output logic [CNT_WIDTH-1:0] ties,
    output logic [SEQ_WIDTH-1:0] pe_seq,
    output logic                 pe_valid,
    input  logic [SEQ_WIDTH-1:0] res_seq,
    input  logic [E_WIDTH-1:0]   res_e,
    input  logic                 res_valid
);

    state_t               state_q, state_d;
    logic [SEQ_WIDTH-1:0] cur_q, cur_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] returned_q, returned_d;
    logic [SEQ_WIDTH-1:0] pe_seq_d;
    logic                 pe_valid_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 trk_clear;
    logic                 trk_valid;

    // Next-state and datapath; an accepted start issues cfg_first on the same edge.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        count_d    = count_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        pe_seq_d   = pe_seq;
        pe_valid_d = 1'b0;
        trk_clear  = 1'b0;
        trk_valid  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    trk_clear  = 1'b1;
                    count_d    = cfg_count;
                    issued_d   = '0;
                    returned_d = '0;
                    cur_d      = cfg_first;
                    if (cfg_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        if (!hold) begin
                            pe_valid_d = 1'b1;
                            pe_seq_d   = cfg_first;
                            cur_d      = cfg_first + SEQ_WIDTH'(1);
                            issued_d   = CNT_WIDTH'(1);
                            if (cfg_count == CNT_WIDTH'(1)) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
            end
            ST_RUN: begin
                trk_valid = res_valid;
                if (res_valid) begin
                    returned_d = returned_q + CNT_WIDTH'(1);
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    pe_valid_d = 1'b1;
                    pe_seq_d   = cur_q;
                    cur_d      = cur_q + SEQ_WIDTH'(1);
                    issued_d   = issued_q + CNT_WIDTH'(1);
                    if (issued_d == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                trk_valid = res_valid;
                if (res_valid) begin
                    returned_d = returned_q + CNT_WIDTH'(1);
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (res_valid && (returned_d == count_q)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            pe_seq     <= '0;
            pe_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            pe_seq     <= pe_seq_d;
            pe_valid   <= pe_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    labs_best_tracker #(
        .SEQ_WIDTH (SEQ_WIDTH),
        .E_WIDTH   (E_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_best (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (trk_clear),
        .valid    (trk_valid),
        .res_seq  (res_seq),
        .res_e    (res_e),
        .best_seq (best_seq),
        .best_e   (best_e),
        .ties     (ties)
    );

endmodule

// File: tb/tb_labs_search_ctrl.sv
// Directed bench for labs_search_ctrl with a 9-stage stub energy pipeline.
module tb_labs_search_ctrl;

    localparam int unsigned SW = 8;
    localparam int unsigned EW = 20;
    localparam int unsigned CW = 16;
    localparam int unsigned L  = 9;
    localparam int          NC = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] cfg_first;
    logic [CW-1:0] cfg_count;
    logic          start, abort, hold;
    logic          busy, done;
    logic [SW-1:0] best_seq;
    logic [EW-1:0] best_e;
    logic [CW-1:0] ties;
    logic [SW-1:0] pe_seq;
    logic          pe_valid;
    logic [SW-1:0] res_seq;
    logic [EW-1:0] res_e;
    logic          res_valid;

    int errors = 0;
    int checks = 0;

    logic [NC-1:0] pv_mask, busy_mask, done_mask;
    logic [SW-1:0] seqs[$];

    always #5 clk = ~clk;

    labs_search_ctrl #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_first (cfg_first),
        .cfg_count (cfg_count),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .best_seq  (best_seq),
        .best_e    (best_e),
        .ties      (ties),
        .pe_seq    (pe_seq),
        .pe_valid  (pe_valid),
        .res_seq   (res_seq),
        .res_e     (res_e),
        .res_valid (res_valid)
    );

    // Stub calc_e: fixed latency L, energy looked up per sequence.
    function automatic logic [EW-1:0] energy(input logic [SW-1:0] s);
        case (s)
            8'h10:   energy = 20'd14;
            8'h11:   energy = 20'd2;
            8'h12:   energy = 20'd2;
            8'h13:   energy = 20'd6;
            default: energy = 20'd100 + EW'(s);
        endcase
    endfunction

    logic [L-1:0]  vp;
    logic [SW-1:0] sp[L];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp <= '0;
            for (int i = 0; i < L; i++) sp[i] <= '0;
        end else begin
            vp    <= {vp[L-2:0], pe_valid};
            sp[0] <= pe_seq;
            for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
        end
    end

    assign res_valid = vp[L-1];
    assign res_seq   = sp[L-1];
    assign res_e     = energy(res_seq);

    // Runs NC cycles; cycle 0 carries start. Inputs change 1 time unit after posedge.
    task automatic run(input logic [SW-1:0] first, input logic [CW-1:0] count,
                       input logic [NC-1:0] hold_m, input int abort_c, input int restart_c);
        pv_mask   = '0;
        busy_mask = '0;
        done_mask = '0;
        seqs.delete();
        for (int c = 0; c < NC; c++) begin
            start     = (c == 0) || (c == restart_c);
            cfg_first = (c == restart_c) ? 8'h80 : first;
            cfg_count = (c == restart_c) ? 16'd2 : count;
            abort     = (c == abort_c);
            hold      = hold_m[c];
            @(negedge clk);
            pv_mask[c]   = pe_valid;
            busy_mask[c] = busy;
            done_mask[c] = done;
            if (pe_valid) seqs.push_back(pe_seq);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        cfg_first = '0; cfg_count = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, pe_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags busy/done/pe_valid=%b want 000", {busy, done, pe_valid}); end
        checks++; if (pe_seq !== 8'h00) begin errors++; $display("FAIL reset_pe_seq got %h want 00", pe_seq); end
        checks++; if (best_e !== 20'hFFFFF) begin errors++; $display("FAIL reset_best_e got %h want FFFFF", best_e); end
        checks++; if ({best_seq, ties} !== 24'h0) begin errors++; $display("FAIL reset_best_seq_ties got %h/%h want 0/0", best_seq, ties); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [SW-1:0] exp_s[4];
        exp_s = '{8'h10, 8'h11, 8'h12, 8'h13};
        run(8'h10, 16'd4, '0, -1, -1);
        checks++; if (pv_mask !== 32'h0000_001E) begin errors++; $display("FAIL basic_pe_valid got %h want 0000001e", pv_mask); end
        checks++; if (seqs.size() !== 4) begin errors++; $display("FAIL basic_issue_count got %0d want 4", seqs.size()); end
        for (int i = 0; i < 4 && i < seqs.size(); i++) begin
            checks++; if (seqs[i] !== exp_s[i]) begin errors++; $display("FAIL basic_pe_seq[%0d] got %h want %h", i, seqs[i], exp_s[i]); end
        end
        checks++; if (busy_mask !== 32'h0000_3FFE) begin errors++; $display("FAIL basic_busy got %h want 00003ffe", busy_mask); end
        checks++; if (done_mask !== 32'hFFFF_C000) begin errors++; $display("FAIL basic_done got %h want ffffc000", done_mask); end
        checks++; if (best_e !== 20'd2) begin errors++; $display("FAIL basic_best_e got %0d want 2", best_e); end
        checks++; if (best_seq !== 8'h11) begin errors++; $display("FAIL basic_best_seq got %h want 11", best_seq); end
        checks++; if (ties !== 16'd2) begin errors++; $display("FAIL basic_ties got %0d want 2", ties); end
    endtask

    task automatic test_wrap();
        logic [SW-1:0] exp_s[3];
        exp_s = '{8'hFE, 8'hFF, 8'h00};
        run(8'hFE, 16'd3, '0, -1, -1);
        checks++; if (pv_mask !== 32'h0000_000E) begin errors++; $display("FAIL wrap_pe_valid got %h want 0000000e", pv_mask); end
        checks++; if (seqs.size() !== 3) begin errors++; $display("FAIL wrap_issue_count got %0d want 3", seqs.size()); end
        for (int i = 0; i < 3 && i < seqs.size(); i++) begin
            checks++; if (seqs[i] !== exp_s[i]) begin errors++; $display("FAIL wrap_pe_seq[%0d] got %h want %h", i, seqs[i], exp_s[i]); end
        end
        checks++; if (busy_mask !== 32'h0000_1FFE) begin errors++; $display("FAIL wrap_busy got %h want 00001ffe", busy_mask); end
        checks++; if (done_mask !== 32'hFFFF_E001) begin errors++; $display("FAIL wrap_done got %h want ffffe001", done_mask); end
        checks++; if ({best_e, best_seq, ties} !== {20'd100, 8'h00, 16'd1}) begin errors++; $display("FAIL wrap_best got e=%0d seq=%h ties=%0d want e=100 seq=00 ties=1", best_e, best_seq, ties); end
    endtask

    task automatic test_zero_count();
        run(8'h10, 16'd0, '0, -1, -1);
        checks++; if (pv_mask !== 32'h0) begin errors++; $display("FAIL zero_pe_valid got %h want 00000000", pv_mask); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL zero_busy got %h want 00000000", busy_mask); end
        checks++; if (done_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_done got %h want ffffffff", done_mask); end
        checks++; if ({best_e, best_seq, ties} !== {20'hFFFFF, 8'h00, 16'd0}) begin errors++; $display("FAIL zero_best got e=%h seq=%h ties=%0d want e=fffff seq=00 ties=0", best_e, best_seq, ties); end
    endtask

    // start together with abort from DONE: abort wins and the block drops to IDLE.
    task automatic test_abort_start();
        run(8'h10, 16'd4, '0, 0, -1);
        checks++; if (pv_mask !== 32'h0) begin errors++; $display("FAIL abort_start_pe_valid got %h want 00000000", pv_mask); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL abort_start_busy got %h want 00000000", busy_mask); end
        checks++; if (done_mask !== 32'h0000_0001) begin errors++; $display("FAIL abort_start_done got %h want 00000001", done_mask); end
    endtask

    // hold asserted during cycles 1-2 suppresses issue in cycles 2-3.
    task automatic test_hold();
        logic [SW-1:0] exp_s[4];
        exp_s = '{8'h10, 8'h11, 8'h12, 8'h13};
        run(8'h10, 16'd4, 32'h0000_0006, -1, -1);
        checks++; if (pv_mask !== 32'h0000_0072) begin errors++; $display("FAIL hold_pe_valid got %h want 00000072", pv_mask); end
        checks++; if (seqs.size() !== 4) begin errors++; $display("FAIL hold_issue_count got %0d want 4", seqs.size()); end
        for (int i = 0; i < 4 && i < seqs.size(); i++) begin
            checks++; if (seqs[i] !== exp_s[i]) begin errors++; $display("FAIL hold_pe_seq[%0d] got %h want %h", i, seqs[i], exp_s[i]); end
        end
        checks++; if (busy_mask !== 32'h0000_FFFE) begin errors++; $display("FAIL hold_busy got %h want 0000fffe", busy_mask); end
        checks++; if (done_mask !== 32'hFFFF_0000) begin errors++; $display("FAIL hold_done got %h want ffff0000", done_mask); end
        checks++; if ({best_e, best_seq, ties} !== {20'd2, 8'h11, 16'd2}) begin errors++; $display("FAIL hold_best got e=%0d seq=%h ties=%0d want e=2 seq=11 ties=2", best_e, best_seq, ties); end
    endtask

    // Abort in cycle 3 with an ignored restart in cycle 2; stale results land in IDLE.
    task automatic test_abort();
        logic [SW-1:0] exp_s[3];
        exp_s = '{8'h10, 8'h11, 8'h12};
        run(8'h10, 16'd4, '0, 3, 2);
        checks++; if (pv_mask !== 32'h0000_000E) begin errors++; $display("FAIL abort_pe_valid got %h want 0000000e", pv_mask); end
        checks++; if (seqs.size() !== 3) begin errors++; $display("FAIL abort_issue_count got %0d want 3", seqs.size()); end
        for (int i = 0; i < 3 && i < seqs.size(); i++) begin
            checks++; if (seqs[i] !== exp_s[i]) begin errors++; $display("FAIL abort_pe_seq[%0d] got %h want %h", i, seqs[i], exp_s[i]); end
        end
        checks++; if (busy_mask !== 32'h0000_000E) begin errors++; $display("FAIL abort_busy got %h want 0000000e", busy_mask); end
        checks++; if (done_mask !== 32'h0000_0001) begin errors++; $display("FAIL abort_done got %h want 00000001", done_mask); end
        checks++; if ({best_e, ties} !== {20'hFFFFF, 16'd0}) begin errors++; $display("FAIL abort_stale got e=%h ties=%0d want e=fffff ties=0", best_e, ties); end
    endtask

    // Reset asserted mid-cycle in DRAIN must clear outputs without a clock edge.
    task automatic test_async_reset();
        start = 1'b1; cfg_first = 8'h10; cfg_count = 16'd4; abort = 1'b0; hold = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        #2;
        checks++; if ({busy, best_e} !== {1'b1, 20'd14}) begin errors++; $display("FAIL areset_pre busy=%b e=%0d want busy=1 e=14", busy, best_e); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, pe_valid, pe_seq} !== 11'h0) begin errors++; $display("FAIL areset_ctrl busy=%b done=%b pv=%b seq=%h want all 0", busy, done, pe_valid, pe_seq); end
        checks++; if ({best_e, best_seq, ties} !== {20'hFFFFF, 8'h00, 16'd0}) begin errors++; $display("FAIL areset_best e=%h seq=%h ties=%0d want fffff/00/0", best_e, best_seq, ties); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, pe_valid} !== 3'b000) begin errors++; $display("FAIL areset_post busy/done/pv=%b want 000", {busy, done, pe_valid}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_abort_start();
        test_hold();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
